dma_bus_master: RTL

- Multi-channel cycle-stealing DMA master for the 6502 bus. It generalises the single-channel OAM DMA ($4014) to N channels, each with a programmable length and destination.
- While a transfer runs, it halts the CPU through the CPU's CE input and drives ADDR/DOUT/WREQ in the CPU's place.
- It sits between the CPU and the memory/PPU decode, next to the bus mux.

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_bus_master_if.sv | 29 ++
 rtl/dma_arbiter.sv | 23 ++
 rtl/dma_bus_master.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the cycle-stealing DMA master: FSM encoding,
// register offsets and the length decode helper.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_GET,
        ST_PUT
    } dma_state_e;

    localparam logic [1:0] OFS_DST_LO   = 2'd0;
    localparam logic [1:0] OFS_DST_HI   = 2'd1;
    localparam logic [1:0] OFS_LEN      = 2'd2;
    localparam logic [1:0] OFS_SRC_PAGE = 2'd3;

    // A programmed length of zero stands for a full page.
    localparam bit LEN_ZERO_IS_256 = 1'b1;

    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        if (len == 8'd0 && LEN_ZERO_IS_256) begin
            return 9'd256;
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/dma_bus_master_if.sv
// Register-write port and 6502 bus side of the DMA master, grouped as one
// interface; master = DMA block, slave = CPU decode / bus mux side.
interface dma_bus_master_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 16,
    parameter int CH_W     = 1
);
    logic                REG_WE;
    logic [CH_W+1:0]     REG_ADDR;
    logic [7:0]          REG_DATA;
    logic                CPU_HALT;
    logic                BUS_OWN;
    logic [ADDR_W-1:0]   BUS_ADDR;
    logic [7:0]          BUS_DIN;
    logic [7:0]          BUS_DOUT;
    logic                BUS_WREQ;
    logic [CHANNELS-1:0] BUSY;
    logic [CHANNELS-1:0] DONE;

    modport master (
        input  REG_WE, REG_ADDR, REG_DATA, BUS_DIN,
        output CPU_HALT, BUS_OWN, BUS_ADDR, BUS_DOUT, BUS_WREQ, BUSY, DONE
    );

    modport slave (
        output REG_WE, REG_ADDR, REG_DATA, BUS_DIN,
        input  CPU_HALT, BUS_OWN, BUS_ADDR, BUS_DOUT, BUS_WREQ, BUSY, DONE
    );
endinterface

// File: rtl/dma_arbiter.sv
// Fixed-priority request picker: the lowest set index wins, reported both
// as a one-hot grant and as a binary index.
module dma_arbiter #(
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] grant,
    output logic [CH_W-1:0]     idx,
    output logic                any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = CHANNELS'(1) << i;
                idx   = CH_W'(i);
            end
        end
    end
endmodule

// File: rtl/dma_bus_master.sv
// Multi-channel cycle-stealing DMA master for the 6502 bus (OAM DMA style).
// Define DMA_DST_INC_EN to make DST an auto-incrementing pointer.
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 16,
    parameter int CH_W     = 1
) (
    input logic              CLK,
    input logic              RST,
    dma_bus_master_if.master bus
);
    dma_state_e          state_q, state_d;
    logic                parity;
    logic [CH_W-1:0]     cur_q;
    logic [CHANNELS-1:0] cur_oh_q;
    logic [8:0]          count_q;
    logic [7:0]          latch_q;
    logic [CHANNELS-1:0] busy_q, done_q;
    logic [15:0]         dst_q [CHANNELS];
    logic [15:0]         src_q [CHANNELS];
    logic [7:0]          len_q [CHANNELS];

    logic [CH_W-1:0]     wr_ch;
    logic [1:0]          wr_ofs;
    logic                wr_ok;
    logic [CHANNELS-1:0] trig, req, win_oh;
    logic [CH_W-1:0]     win_idx;
    logic                req_any, load, finish;
    logic                cpu_halt, bus_own, bus_wreq;
    logic [ADDR_W-1:0]   bus_addr;
    logic [7:0]          bus_dout;

    assign wr_ch  = bus.REG_ADDR[CH_W+1:2];
    assign wr_ofs = bus.REG_ADDR[1:0];
    assign wr_ok  = bus.REG_WE && (int'(wr_ch) < CHANNELS) && !busy_q[wr_ch];

    // A trigger in the current cycle is visible to IDLE so the halt starts
    // on the very next edge.
    always_comb begin
        trig = '0;
        if (wr_ok && wr_ofs == OFS_SRC_PAGE) begin
            trig[wr_ch] = 1'b1;
        end
    end

    assign req = busy_q | trig;

    dma_arbiter #(.CHANNELS(CHANNELS), .CH_W(CH_W)) u_arb (
        .req   (req),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (req_any)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        finish   = 1'b0;
        cpu_halt = 1'b0;
        bus_own  = 1'b0;
        bus_wreq = 1'b0;
        bus_addr = '0;
        bus_dout = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    load    = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                cpu_halt = 1'b1;
                // GET must land on parity 0; insert ALIGN when it would not.
                state_d  = parity ? ST_GET : ST_ALIGN;
            end
            ST_ALIGN: begin
                cpu_halt = 1'b1;
                state_d  = ST_GET;
            end
            ST_GET: begin
                cpu_halt = 1'b1;
                bus_own  = 1'b1;
                bus_addr = ADDR_W'(src_q[cur_q]);
                state_d  = ST_PUT;
            end
            ST_PUT: begin
                cpu_halt = 1'b1;
                bus_own  = 1'b1;
                bus_wreq = 1'b1;
                bus_addr = ADDR_W'(dst_q[cur_q]);
                bus_dout = latch_q;
                if (count_q == 9'd1) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            parity   <= 1'b0;
            busy_q   <= '0;
            done_q   <= '0;
            cur_q    <= '0;
            cur_oh_q <= '0;
            count_q  <= '0;
            latch_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                dst_q[i] <= '0;
                src_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            parity <= ~parity;
            done_q <= finish ? cur_oh_q : '0;
            busy_q <= (busy_q | trig) & ~(finish ? cur_oh_q : '0);

            // Busy channels reject writes, so these never collide with the
            // pointer updates of the active channel below.
            if (wr_ok) begin
                case (wr_ofs)
                    OFS_DST_LO:   dst_q[wr_ch][7:0]  <= bus.REG_DATA;
                    OFS_DST_HI:   dst_q[wr_ch][15:8] <= bus.REG_DATA;
                    OFS_LEN:      len_q[wr_ch]       <= bus.REG_DATA;
                    default:      src_q[wr_ch]       <= {bus.REG_DATA, 8'h00};
                endcase
            end

            if (load) begin
                cur_q    <= win_idx;
                cur_oh_q <= win_oh;
                count_q  <= len_to_count(len_q[win_idx]);
            end

            if (state_q == ST_GET) begin
                latch_q                <= bus.BUS_DIN;
                src_q[cur_q][7:0]      <= src_q[cur_q][7:0] + 8'd1;
            end

            if (state_q == ST_PUT) begin
                count_q <= count_q - 9'd1;
`ifdef DMA_DST_INC_EN
                dst_q[cur_q] <= dst_q[cur_q] + 16'd1;
`endif
            end
        end
    end

    assign bus.CPU_HALT = cpu_halt;
    assign bus.BUS_OWN  = bus_own;
    assign bus.BUS_ADDR = bus_addr;
    assign bus.BUS_DOUT = bus_dout;
    assign bus.BUS_WREQ = bus_wreq;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule
